seg7_display_mux: RTL
=====================

# seg7_display_mux

Time-multiplexed driver for the board's common-anode 7-segment display bank, sitting directly downstream of the refresh-rate clock divider. On each refresh strobe it:
- blanks all anodes for a programmable guard interval (anti-ghosting);
- advances to the next digit;
- drives that digit's active-low anode together with its decoded cathode pattern and decimal point.

The displayed value is snapshotted once per frame, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- NUM_DIGITS, 8, digits in bank; legal range 2..8.
- BLANK_CYCLES, 64, clk cycles all anodes are held off between digits; legal minimum 1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle refresh strobe in the clk domain (480 Hz nominal), from the divider.
- value  in  4*NUM_DIGITS  hex nibbles; digit 0 = value[3:0].
- dp_mask  in  NUM_DIGITS  1 = light decimal point of digit i.
- blank_mask  in  NUM_DIGITS  1 = force digit i dark.
- lz_en  in  1  1 = suppress leading zeros.
- anode  out  NUM_DIGITS  active-low digit enables.
- seg  out  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse when the last digit turns on.

## Operation
- State machine states:
  - WAIT: after reset, until the first tick.
  - BLANK: guard interval.
  - SHOW: digit lit.
- Reset values:
  - state = WAIT, idx = NUM_DIGITS-1, blank_cnt = 0.
  - anode = all 1s, seg = 7'h7F, dp = 1, frame_done = 0.
  - Shadow registers cleared.
- tick in WAIT or SHOW:
  - state -> BLANK; anode <= all 1s; seg <= 7'h7F; dp <= 1.
  - idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
  - blank_cnt <= BLANK_CYCLES-1.
- Snapshot: when idx wraps to 0, value, dp_mask, blank_mask and lz_en are latched into shadow registers in the same cycle. All decode uses shadow copies only.
- In BLANK:
  - blank_cnt != 0: decrement.
  - blank_cnt == 0: state -> SHOW; anode <= ~(1 << idx); seg and dp loaded for digit idx.
- frame_done = 1 for exactly the cycle SHOW is entered with idx = NUM_DIGITS-1.
- tick during BLANK is ignored: no advance, no counter reload.
- Digit dark (seg = 7'h7F, dp = 1, anode still asserted) if:
  - its shadow blank_mask bit is set, or
  - lz_en is set, the nibble is 0, all higher nibbles are 0, and idx != 0.
  - Digit 0 is never suppressed by lz_en.
  - dp_mask does not override a dark digit.
- Decode is standard hex (0-F):
  - 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E.
- At most one anode bit is low at any time. There are no glitch cycles: all outputs are registered.

## Timing
- tick sampled at edge T → anode all 1s from T+1.
- New digit lit at T+BLANK_CYCLES+1. Anodes are dark for exactly BLANK_CYCLES cycles.
- Inputs changed mid-frame take effect only at the next wrap to digit 0.
- reset asserted at any point, including mid-BLANK, returns to reset values at the next edge. The first tick after reset lights digit 0.
- reset and tick in the same cycle: reset wins; the tick is lost.
- Ticks must be spaced more than BLANK_CYCLES+1 cycles apart. Closer ticks are dropped per the BLANK rule; no error flag is raised.

## Structure
- Shared package seg7_pkg:
  - state enum {WAIT, BLANK, SHOW};
  - SEG_OFF = 7'h7F;
  - the 16-entry hex cathode pattern constants.
- Sub-module seg7_hex_decode: combinational nibble -> 7-bit active-low pattern, instantiated once on the shadow nibble selected by idx.
- The leading-zero detect is a priority scan over shadow nibbles, kept in this block.

## Test plan
- Reset then 8 ticks spaced 1000 cycles apart, value = 32'h0123_4567, BLANK_CYCLES = 64:
  - anode walks FE, FD, …, 7F;
  - seg for digit 0 = 7'h78 ('7'), digit 7 = 7'h40;
  - each digit is preceded by exactly 64 all-dark cycles;
  - frame_done pulses once, at anode 7F.
- value changed from 32'h1111_1111 to 32'h2222_2222 while digit 3 is lit → digits 4-7 still show '1'; '2' appears from the next digit 0.
- lz_en = 1, value = 32'h0000_00A0 → digits 2-7 dark; digit 1 = 7'h08; digit 0 = 7'h40.
- value = 0 with lz_en = 1 → only digit 0 lit, showing '0'.
- dp_mask = 8'h04, blank_mask = 8'h04 → digit 2 fully dark, dp stays 1.
- Second tick 10 cycles after the first (BLANK_CYCLES = 64) → ignored, digit lit at T+65.
- reset pulsed mid-BLANK → all outputs return to reset values next cycle; the next tick lights digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Cathode patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entries packed F (msb) down to 0 (lsb).
  localparam logic [16*7-1:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
    return HEX_TABLE[int'(nibble)*7 +: 7];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment cathode pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_seg(i_nibble);

endmodule

// File: rtl/seg7_display_mux.sv
// Time-multiplexed common-anode 7-segment driver with a blanking guard between
// digits and a once-per-frame snapshot of the displayed value.
module seg7_display_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_blank_cnt;
  logic [4*NUM_DIGITS-1:0] r_value_sh;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [NUM_DIGITS-1:0]   r_blank_sh;
  logic                    r_lz_sh;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_done;

  logic [3:0]            w_nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_upper_zero;
  logic [3:0]            w_nibble_sel;
  logic [6:0]            w_hex_seg;
  logic                  w_dark;
  logic [NUM_DIGITS-1:0] w_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign w_nibbles[gi] = r_value_sh[4*gi +: 4];
    end
  endgenerate

  // w_upper_zero[i] = nibble i and every nibble above it are zero.
  always_comb begin
    logic v_run;
    w_upper_zero = '0;
    v_run        = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_run           = v_run & (w_nibbles[i] == 4'h0);
      w_upper_zero[i] = v_run;
    end
  end

  assign w_nibble_sel = w_nibbles[r_idx];
  assign w_onehot     = NUM_DIGITS'(1) << r_idx;
  assign w_dark       = r_blank_sh[r_idx] |
                        (r_lz_sh & w_upper_zero[r_idx] & (r_idx != '0));

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble_sel),
    .o_seg    (w_hex_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= WAIT;
      r_idx        <= LAST_IDX;
      r_blank_cnt  <= '0;
      r_value_sh   <= '0;
      r_dp_sh      <= '0;
      r_blank_sh   <= '0;
      r_lz_sh      <= 1'b0;
      r_anode      <= '1;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        WAIT, SHOW: begin
          if (tick) begin
            r_state     <= BLANK;
            r_anode     <= '1;
            r_seg       <= SEG_OFF;
            r_dp        <= 1'b1;
            r_blank_cnt <= CNT_LOAD;
            if (r_idx == LAST_IDX) begin
              // Frame boundary: freeze inputs for the whole next frame.
              r_idx      <= '0;
              r_value_sh <= value;
              r_dp_sh    <= dp_mask;
              r_blank_sh <= blank_mask;
              r_lz_sh    <= lz_en;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        BLANK: begin
          if (r_blank_cnt != '0) begin
            r_blank_cnt <= r_blank_cnt - CNT_W'(1);
          end else begin
            r_state      <= SHOW;
            r_anode      <= ~w_onehot;
            r_seg        <= w_dark ? SEG_OFF : w_hex_seg;
            r_dp         <= w_dark | ~r_dp_sh[r_idx];
            r_frame_done <= (r_idx == LAST_IDX);
          end
        end
        default: r_state <= WAIT;
      endcase
    end
  end

  assign anode      = r_anode;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule
